bram_msg_writer: RTL and testbench
==================================

Name: bram_msg_writer

Overview:
- Write-side companion to the BRAM-backed eight-digit scroll display; drives BRAM port A (ena/wea/addra/dina) of the message memory.
- The display path reads the same memory on port B.
- Assembles 4-bit hex nibbles (debounced switch/button pulses from the top level) into 32-bit words and writes them sequentially from address 0.
- Supports explicit commit of a partial word and a full-memory clear sweep.

Parameters:
DEPTH, 16, number of 32-bit message words in the BRAM
ADDR_W, 4, address width; must satisfy 2**ADDR_W >= DEPTH

Ports:
CLK100MHZ  input  1  system clock, 100 MHz
CPU_RESETN  input  1  reset, asynchronous, active-low
nib_in  input  4  hex nibble to append
nib_valid  input  1  single-cycle pulse: append nib_in
commit  input  1  single-cycle pulse: write the current partial word now
clear  input  1  single-cycle pulse: zero all DEPTH words, reset pointer
ena  output  1  BRAM port A enable
wea  output  1  BRAM port A write enable
addra  output  ADDR_W  BRAM port A address
dina  output  32  BRAM port A write data
word_count  output  ADDR_W+1  words written since reset/clear, 0..DEPTH
entry_word  output  32  current assembly register, for preview
nib_cnt  output  4  nibbles in assembly register, 0..7
busy  output  1  high in WRITE or CLEAR state
full  output  1  word_count == DEPTH

Behaviour:
- Reset: all outputs 0; state IDLE; wr_ptr = 0; entry_word = 0.
- Reset mid-sweep or mid-write aborts immediately; the BRAM is left partially updated. This is acceptable.
- States:
  - IDLE: accepts inputs.
  - WRITE: one cycle, issues the write.
  - CLEAR: DEPTH cycles, writes zeros.
- Input priority in IDLE, same cycle: clear > commit > nib_valid; lower-priority pulses are dropped.
- All inputs are ignored outside IDLE and while full. Exception: clear is still accepted in IDLE while full.
- Nibble append:
  - entry_word <= {entry_word[27:0], nib_in}; nib_cnt increments.
  - The first nibble lands in [3:0] and shifts left, so after 8 nibbles the first-entered nibble is in [31:28] (leftmost digit).
  - On the 8th nibble (nib_cnt == 7): next state WRITE, dina <= new word, addra <= wr_ptr; nib_cnt and entry_word clear to 0.
- Commit:
  - If nib_cnt > 0: next state WRITE with dina = entry_word (right-justified, upper bits 0); nib_cnt and entry_word clear.
  - If nib_cnt == 0: no-op.
- WRITE state:
  - ena = wea = 1 for exactly one cycle, one cycle after the triggering pulse.
  - wr_ptr and word_count increment.
  - Return to IDLE.
- Latency: pulse at cycle N -> wea high at N+1 -> nib_valid accepted again at N+2.
- Full: when word_count reaches DEPTH, full = 1. No wrap; the pointer holds at DEPTH-1 and no further writes occur until clear.
- Clear sweep:
  - Enter CLEAR; ena = wea = 1, dina = 0, addra counts 0..DEPTH-1, one per cycle.
  - Exit to IDLE after address DEPTH-1.
  - On exit: wr_ptr, word_count, nib_cnt and entry_word are all 0, and full = 0.
- ena and wea are 0 in IDLE. addra and dina hold their last values in IDLE.
- All outputs are registered.

Test Plan:
- Reset, then nibbles 1,2,3,4,5,6,7,8 on successive pulses -> one cycle with wea=1, addra=0, dina=32'h12345678; word_count=1, nib_cnt=0.
- Nibbles A, B, then commit -> wea pulse at addra=1 with dina=32'h000000AB; a commit with nib_cnt=0 produces no wea.
- clear, commit and nib_valid asserted in the same IDLE cycle -> clear sweep only: 16 consecutive wea cycles with addra 0..15 and dina=0; afterwards word_count=0, nib_cnt=0, entry_word=0.
- Write 16 full words -> full=1, word_count=16; a further 8 nibbles and a commit produce no wea and leave entry_word unchanged; clear restores full=0.
- nib_valid pulsed on the cycle wea is high (WRITE state) -> the nibble is ignored and nib_cnt stays 0.
- CPU_RESETN asserted at sweep address 5 -> ena and wea drop immediately (asynchronously); after release, state is IDLE, addra=0, word_count=0.

Source files
------------

// File: rtl/bram_msg_writer_if.sv
// Nibble-entry controls in, BRAM port A write bus and status out.
// The writer connects to the master side; whatever drives the keys and reads status uses slave.
interface bram_msg_writer_if #(
    parameter int ADDR_W = 4
);
    logic [3:0]        nib_in;
    logic              nib_valid;
    logic              commit;
    logic              clear;
    logic              ena;
    logic              wea;
    logic [ADDR_W-1:0] addra;
    logic [31:0]       dina;
    logic [ADDR_W:0]   word_count;
    logic [31:0]       entry_word;
    logic [3:0]        nib_cnt;
    logic              busy;
    logic              full;

    modport master (
        input  nib_in, nib_valid, commit, clear,
        output ena, wea, addra, dina, word_count, entry_word, nib_cnt, busy, full
    );

    modport slave (
        output nib_in, nib_valid, commit, clear,
        input  ena, wea, addra, dina, word_count, entry_word, nib_cnt, busy, full
    );
endinterface

// File: rtl/bram_msg_writer.sv
// Packs hex nibbles into 32-bit words and writes them sequentially into BRAM port A.
// Also performs a zero-fill sweep of the whole memory on clear.
module bram_msg_writer #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic               CLK100MHZ,
    input  logic               CPU_RESETN,
    bram_msg_writer_if.master  bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_CLEAR = 2'd2;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   FULL_CNT  = (ADDR_W + 1)'(DEPTH);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W:0]   r_word_count;
    logic [31:0]       r_entry;
    logic [3:0]        r_nib_cnt;
    logic              r_ena;
    logic              r_wea;
    logic [ADDR_W-1:0] r_addra;
    logic [31:0]       r_dina;
    logic              r_busy;
    logic              r_full;

    logic [31:0]       w_shifted;
    logic              w_do_write;
    logic [31:0]       w_wr_data;
    logic              w_accept;

    assign w_shifted = {r_entry[27:0], bus.nib_in};
    assign w_accept  = (r_state == S_IDLE) && !bus.clear && !r_full;

    // Commit outranks nib_valid even when it turns out to be a no-op.
    always_comb begin
        w_do_write = 1'b0;
        w_wr_data  = r_entry;
        if (w_accept) begin
            if (bus.commit) begin
                w_do_write = (r_nib_cnt != 4'd0);
            end else if (bus.nib_valid && r_nib_cnt == 4'd7) begin
                w_do_write = 1'b1;
                w_wr_data  = w_shifted;
            end
        end
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_word_count <= '0;
            r_entry      <= '0;
            r_nib_cnt    <= '0;
            r_ena        <= 1'b0;
            r_wea        <= 1'b0;
            r_addra      <= '0;
            r_dina       <= '0;
            r_busy       <= 1'b0;
            r_full       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.clear) begin
                        r_state   <= S_CLEAR;
                        r_ena     <= 1'b1;
                        r_wea     <= 1'b1;
                        r_busy    <= 1'b1;
                        r_addra   <= '0;
                        r_dina    <= '0;
                        r_entry   <= '0;
                        r_nib_cnt <= '0;
                    end else if (w_do_write) begin
                        r_state   <= S_WRITE;
                        r_ena     <= 1'b1;
                        r_wea     <= 1'b1;
                        r_busy    <= 1'b1;
                        r_addra   <= r_wr_ptr;
                        r_dina    <= w_wr_data;
                        r_entry   <= '0;
                        r_nib_cnt <= '0;
                    end else if (w_accept && !bus.commit && bus.nib_valid) begin
                        r_entry   <= w_shifted;
                        r_nib_cnt <= r_nib_cnt + 4'd1;
                    end
                end
                S_WRITE: begin
                    r_state      <= S_IDLE;
                    r_ena        <= 1'b0;
                    r_wea        <= 1'b0;
                    r_busy       <= 1'b0;
                    r_word_count <= r_word_count + 1'b1;
                    r_full       <= (r_word_count + 1'b1) == FULL_CNT;
                    // Pointer parks on the last word rather than wrapping.
                    if (r_wr_ptr != LAST_ADDR)
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                S_CLEAR: begin
                    if (r_addra == LAST_ADDR) begin
                        r_state      <= S_IDLE;
                        r_ena        <= 1'b0;
                        r_wea        <= 1'b0;
                        r_busy       <= 1'b0;
                        r_wr_ptr     <= '0;
                        r_word_count <= '0;
                        r_full       <= 1'b0;
                    end else begin
                        r_addra <= r_addra + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ena   <= 1'b0;
                    r_wea   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ena        = r_ena;
    assign bus.wea        = r_wea;
    assign bus.addra      = r_addra;
    assign bus.dina       = r_dina;
    assign bus.word_count = r_word_count;
    assign bus.entry_word = r_entry;
    assign bus.nib_cnt    = r_nib_cnt;
    assign bus.busy       = r_busy;
    assign bus.full       = r_full;
endmodule

// File: tb/tb_bram_msg_writer.sv
// Directed bench: a transaction-level model predicts the BRAM write stream and status,
// and a per-cycle compare process checks port A against it.
module tb_bram_msg_writer;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bram_msg_writer_if #(.ADDR_W(ADDR_W)) bif();

    bram_msg_writer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .CLK100MHZ (clk),
        .CPU_RESETN(rst_n),
        .bus       (bif)
    );

    typedef struct {
        int                c;
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
    } wr_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit run   = 0;

    // Model state: expected writes tagged with the cycle they must appear in.
    wr_t       m_q[$];
    bit [3:0]  m_nq[$];
    int        m_ptr, m_count, m_free;
    bit        m_full;

    int          wr_cnt = 0;
    logic [3:0]  last_a;
    logic [31:0] last_d;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] fold();
        logic [31:0] w = '0;
        foreach (m_nq[i]) w = {w[27:0], m_nq[i]};
        return w;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_nq.delete();
        m_ptr = 0; m_count = 0; m_free = 0; m_full = 0;
    endtask

    task automatic model_write(int e, logic [31:0] d);
        wr_t w;
        w.c = e; w.a = ADDR_W'(m_ptr); w.d = d;
        m_q.push_back(w);
        m_nq.delete();
        m_count++;
        if (m_ptr < DEPTH - 1) m_ptr++;
        m_full = (m_count == DEPTH);
        m_free = e + 2;
    endtask

    // e is the clock edge at which the DUT samples this pulse.
    task automatic model_apply(int e, bit nv, bit [3:0] n, bit cm, bit cl);
        if (e < m_free) return;
        if (cl) begin
            for (int i = 0; i < DEPTH; i++) begin
                wr_t w;
                w.c = e + i; w.a = ADDR_W'(i); w.d = '0;
                m_q.push_back(w);
            end
            m_nq.delete();
            m_ptr = 0; m_count = 0; m_full = 0;
            m_free = e + DEPTH + 1;
        end else if (m_full) begin
            return;
        end else if (cm) begin
            if (m_nq.size() > 0) model_write(e, fold());
        end else if (nv) begin
            m_nq.push_back(n);
            if (m_nq.size() == 8) model_write(e, fold());
        end
    endtask

    task automatic pulse(bit nv, bit [3:0] n, bit cm, bit cl);
        bif.nib_in    = n;
        bif.nib_valid = nv;
        bif.commit    = cm;
        bif.clear     = cl;
        model_apply(cyc + 1, nv, n, cm, cl);
        @(posedge clk); #1;
        bif.nib_valid = 1'b0;
        bif.commit    = 1'b0;
        bif.clear     = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic chk_state();
        chk("word_count", 64'(bif.word_count), 64'(m_count));
        chk("nib_cnt", 64'(bif.nib_cnt), 64'(m_nq.size()));
        chk("entry_word", 64'(bif.entry_word), 64'(fold()));
        chk("full", 64'(bif.full), 64'(m_full));
    endtask

    // Per-cycle check of the port A stream and busy against the model.
    always @(negedge clk) begin
        if (rst_n && run) begin
            bit exp_w;
            while (m_q.size() > 0 && m_q[0].c < cyc) begin
                chk("missed_write_addr", 64'(1), 64'(0));
                void'(m_q.pop_front());
            end
            exp_w = (m_q.size() > 0 && m_q[0].c == cyc);
            chk("ena_wea_busy", 64'({bif.ena, bif.wea, bif.busy}), 64'({3{exp_w}}));
            if (exp_w) begin
                chk("addra", 64'(bif.addra), 64'(m_q[0].a));
                chk("dina", 64'(bif.dina), 64'(m_q[0].d));
                void'(m_q.pop_front());
            end
            if (bif.wea) begin
                wr_cnt++;
                last_a = bif.addra;
                last_d = bif.dina;
            end
        end
    end

    initial begin
        int saved;
        bif.nib_in = '0; bif.nib_valid = 0; bif.commit = 0; bif.clear = 0;
        model_reset();
        idle(3);
        chk("rst_ena", 64'(bif.ena), 64'(0));
        chk("rst_wea", 64'(bif.wea), 64'(0));
        chk("rst_addra", 64'(bif.addra), 64'(0));
        chk("rst_dina", 64'(bif.dina), 64'(0));
        chk("rst_busy_full", 64'({bif.busy, bif.full}), 64'(0));
        chk("rst_counts", 64'({bif.word_count, bif.nib_cnt, bif.entry_word}), 64'(0));
        rst_n = 1'b1;
        run = 1;
        idle(2);

        // Eight nibbles form one word, first nibble leftmost.
        for (int i = 1; i <= 8; i++) pulse(1, 4'(i), 0, 0);
        idle(3);
        chk("lit_word0_data", 64'(last_d), 64'(32'h12345678));
        chk("lit_word0_addr", 64'(last_a), 64'(0));
        chk("lit_word_count1", 64'(bif.word_count), 64'(1));
        chk_state();

        // Partial word commit is right-justified; empty commit does nothing.
        pulse(1, 4'hA, 0, 0);
        pulse(1, 4'hB, 0, 0);
        pulse(0, 4'h0, 1, 0);
        idle(3);
        chk("lit_commit_data", 64'(last_d), 64'(32'h000000AB));
        chk("lit_commit_addr", 64'(last_a), 64'(1));
        saved = wr_cnt;
        pulse(0, 4'h0, 1, 0);
        idle(3);
        chk("empty_commit_nowrite", 64'(wr_cnt), 64'(saved));
        chk_state();

        // Nibble landing on the write cycle is dropped.
        for (int i = 0; i < 8; i++) pulse(1, 4'(15 - i), 0, 0);
        pulse(1, 4'h9, 0, 0);
        idle(3);
        chk("lit_nib_in_write", 64'(bif.nib_cnt), 64'(0));
        chk_state();

        // Clear wins over commit and nib_valid in the same cycle.
        pulse(1, 4'h3, 0, 0);
        pulse(1, 4'h4, 0, 0);
        saved = wr_cnt;
        pulse(1, 4'h5, 1, 1);
        idle(DEPTH + 3);
        chk("lit_clear_writes", 64'(wr_cnt - saved), 64'(DEPTH));
        chk("lit_clear_state", 64'({bif.word_count, bif.nib_cnt, bif.entry_word}), 64'(0));
        chk_state();

        // Fill the memory, then confirm everything but clear is ignored.
        for (int w = 0; w < DEPTH; w++) begin
            for (int j = 0; j < 8; j++) pulse(1, 4'((w + j) % 16), 0, 0);
            idle(1);
        end
        idle(3);
        chk("lit_full", 64'(bif.full), 64'(1));
        chk("lit_full_count", 64'(bif.word_count), 64'(DEPTH));
        chk("lit_full_ptr_last", 64'(last_a), 64'(DEPTH - 1));
        saved = wr_cnt;
        for (int j = 0; j < 8; j++) pulse(1, 4'(j), 0, 0);
        pulse(0, 4'h0, 1, 0);
        idle(3);
        chk("full_no_write", 64'(wr_cnt), 64'(saved));
        chk("lit_full_entry", 64'(bif.entry_word), 64'(0));
        chk_state();
        pulse(0, 4'h0, 0, 1);
        idle(DEPTH + 3);
        chk("lit_full_cleared", 64'(bif.full), 64'(0));
        chk_state();

        // Asynchronous reset in the middle of a sweep.
        pulse(0, 4'h0, 0, 1);
        for (int i = 0; i < 40 && !(bif.wea && bif.addra == 4'd5); i++) begin
            @(posedge clk); #1;
        end
        chk("sweep_reached_5", 64'(bif.addra), 64'(5));
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_ena", 64'(bif.ena), 64'(0));
        chk("async_wea", 64'(bif.wea), 64'(0));
        idle(2);
        rst_n = 1'b1;
        idle(2);
        chk("post_rst_addra", 64'(bif.addra), 64'(0));
        chk("post_rst_count", 64'(bif.word_count), 64'(0));
        chk("post_rst_busy", 64'(bif.busy), 64'(0));
        pulse(1, 4'hC, 0, 0);
        idle(2);
        chk("lit_post_rst_entry", 64'(bif.entry_word), 64'(32'h0000000C));
        chk_state();

        chk("queue_drained", 64'(m_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
